// File: rtl/router_fsm_nch.sv
// Parametrised 1xN router controller: header decode, payload/parity sequencing, FIFO-full stall, bad-address drop.
// Optional WAIT_TILL_EMPTY timeout is built when ROUTER_WAIT_TIMEOUT_EN is defined.
module router_fsm_nch #(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 2,
  parameter int WAIT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_pkt_valid,
  input  logic              i_parity_done,
  input  logic [ADDR_W-1:0] i_data_in,
  input  logic [NUM_CH-1:0] i_soft_reset,
  input  logic              i_fifo_full,
  input  logic              i_low_pkt_valid,
  input  logic [NUM_CH-1:0] i_fifo_empty,
  output logic              o_detect_add,
  output logic              o_ld_state,
  output logic              o_laf_state,
  output logic              o_full_state,
  output logic              o_lfd_state,
  output logic              o_rst_int_reg,
  output logic              o_write_enb_reg,
  output logic              o_busy,
  output logic [NUM_CH-1:0] o_dest_sel,
  output logic              o_addr_err,
  output logic              o_wait_timeout,
  output logic [3:0]        o_state
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  localparam int NPAD = 2 ** ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr_q;
  logic [NPAD-1:0]   w_empty_pad;
  logic [NPAD-1:0]   w_sreset_pad;
  logic              w_hdr_oor;
  logic              w_sreset_hit;
  logic              w_timeout_hit;
  logic              w_wait_timeout;
  logic [NUM_CH-1:0] w_dest;

  // Zero-padding to the full address space makes out-of-range addresses read as not-empty / no-reset.
  always_comb begin
    w_empty_pad  = '0;
    w_sreset_pad = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_empty_pad[i]  = i_fifo_empty[i];
      w_sreset_pad[i] = i_soft_reset[i];
    end
  end

  assign w_hdr_oor    = ({1'b0, i_data_in} >= (ADDR_W+1)'(NUM_CH));
  assign w_sreset_hit = w_sreset_pad[r_addr_q];

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge clock) begin
    if (!resetn)                       r_wait_cnt <= '0;
    else if (r_state == WAIT_TILL_EMPTY) r_wait_cnt <= r_wait_cnt + CW'(1);
    else                               r_wait_cnt <= '0;
  end

  assign w_timeout_hit = (r_wait_cnt == CW'(WAIT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= DECODE_ADDRESS;
      r_addr_q <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS) r_addr_q <= i_data_in;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_wait_timeout = 1'b0;
    case (r_state)
      DECODE_ADDRESS: begin
        if (i_pkt_valid) begin
          if (w_hdr_oor)                   w_next = DROP_PACKET;
          else if (w_empty_pad[i_data_in]) w_next = LOAD_FIRST_DATA;
          else                             w_next = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (i_fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!i_pkt_valid) w_next = LOAD_PARITY;
      end
      LOAD_PARITY:     w_next = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: if (!i_fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (i_parity_done)        w_next = DECODE_ADDRESS;
        else if (i_low_pkt_valid) w_next = LOAD_PARITY;
        else                      w_next = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_pad[r_addr_q]) begin
          w_next = LOAD_FIRST_DATA;
        end else if (w_timeout_hit) begin
          w_next         = DROP_PACKET;
          w_wait_timeout = 1'b1;
        end
      end
      CHECK_PARITY_ERROR: w_next = i_fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      DROP_PACKET:        if (!i_pkt_valid) w_next = DECODE_ADDRESS;
      default:            w_next = DECODE_ADDRESS;
    endcase
    // Channel soft reset aborts whatever the FSM was doing for that channel.
    if (w_sreset_hit) begin
      w_next         = DECODE_ADDRESS;
      w_wait_timeout = 1'b0;
    end
  end

  always_comb begin
    w_dest = '0;
    if (r_state != DECODE_ADDRESS && r_state != DROP_PACKET) begin
      for (int i = 0; i < NUM_CH; i++) w_dest[i] = (r_addr_q == ADDR_W'(i));
    end
  end

  assign o_detect_add    = (r_state == DECODE_ADDRESS);
  assign o_lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign o_ld_state      = (r_state == LOAD_DATA);
  assign o_laf_state     = (r_state == LOAD_AFTER_FULL);
  assign o_full_state    = (r_state == FIFO_FULL_STATE);
  assign o_rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign o_addr_err      = (r_state == DROP_PACKET);
  assign o_write_enb_reg = o_ld_state | o_laf_state | (r_state == LOAD_PARITY);
  assign o_busy          = o_lfd_state | (r_state == LOAD_PARITY) | o_full_state |
                           o_laf_state | (r_state == WAIT_TILL_EMPTY) | o_rst_int_reg;
  assign o_dest_sel      = w_dest;
  assign o_wait_timeout  = w_wait_timeout;
  assign o_state         = r_state;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch: a 3-channel instance and a 5-channel/3-bit-address instance.
// The WAIT timeout steps follow ROUTER_WAIT_TIMEOUT_EN.
module tb_router_fsm_nch;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // Flag order: detect, ld, laf, full, lfd, rst_int, write_enb, busy, addr_err, wait_timeout
  localparam logic [9:0] F_DEC  = 10'b1000000000;
  localparam logic [9:0] F_LFD  = 10'b0000100100;
  localparam logic [9:0] F_LD   = 10'b0100001000;
  localparam logic [9:0] F_LP   = 10'b0000001100;
  localparam logic [9:0] F_FULL = 10'b0001000100;
  localparam logic [9:0] F_LAF  = 10'b0010001100;
  localparam logic [9:0] F_WAIT = 10'b0000000100;
  localparam logic [9:0] F_WTO  = 10'b0000000101;
  localparam logic [9:0] F_CHK  = 10'b0000010100;
  localparam logic [9:0] F_DROP = 10'b0000000010;

  // Instance A: NUM_CH=3, ADDR_W=2
  logic       a_pkt_valid, a_parity_done, a_fifo_full, a_low;
  logic [1:0] a_data_in;
  logic [2:0] a_soft_reset, a_fifo_empty, a_dest;
  logic       a_det, a_ld, a_laf, a_full, a_lfd, a_rst, a_we, a_busy, a_err, a_wto;
  logic [3:0] a_state;

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2)) u_a (
    .clock(clock), .resetn(resetn), .i_pkt_valid(a_pkt_valid), .i_parity_done(a_parity_done),
    .i_data_in(a_data_in), .i_soft_reset(a_soft_reset), .i_fifo_full(a_fifo_full),
    .i_low_pkt_valid(a_low), .i_fifo_empty(a_fifo_empty), .o_detect_add(a_det),
    .o_ld_state(a_ld), .o_laf_state(a_laf), .o_full_state(a_full), .o_lfd_state(a_lfd),
    .o_rst_int_reg(a_rst), .o_write_enb_reg(a_we), .o_busy(a_busy), .o_dest_sel(a_dest),
    .o_addr_err(a_err), .o_wait_timeout(a_wto), .o_state(a_state));

  // Instance B: NUM_CH=5, ADDR_W=3, WAIT_CYCLES=8
  logic       b_pkt_valid, b_parity_done, b_fifo_full, b_low;
  logic [2:0] b_data_in;
  logic [4:0] b_soft_reset, b_fifo_empty, b_dest;
  logic       b_det, b_ld, b_laf, b_full, b_lfd, b_rst, b_we, b_busy, b_err, b_wto;
  logic [3:0] b_state;

  router_fsm_nch #(.NUM_CH(5), .ADDR_W(3), .WAIT_CYCLES(8)) u_b (
    .clock(clock), .resetn(resetn), .i_pkt_valid(b_pkt_valid), .i_parity_done(b_parity_done),
    .i_data_in(b_data_in), .i_soft_reset(b_soft_reset), .i_fifo_full(b_fifo_full),
    .i_low_pkt_valid(b_low), .i_fifo_empty(b_fifo_empty), .o_detect_add(b_det),
    .o_ld_state(b_ld), .o_laf_state(b_laf), .o_full_state(b_full), .o_lfd_state(b_lfd),
    .o_rst_int_reg(b_rst), .o_write_enb_reg(b_we), .o_busy(b_busy), .o_dest_sel(b_dest),
    .o_addr_err(b_err), .o_wait_timeout(b_wto), .o_state(b_state));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] st, input logic [9:0] fl, input logic [2:0] ds);
    check({tag, ".a_state"}, 32'(a_state), 32'(st));
    check({tag, ".a_flags"}, 32'({a_det, a_ld, a_laf, a_full, a_lfd, a_rst, a_we, a_busy, a_err, a_wto}), 32'(fl));
    check({tag, ".a_dest"}, 32'(a_dest), 32'(ds));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] st, input logic [9:0] fl, input logic [4:0] ds);
    check({tag, ".b_state"}, 32'(b_state), 32'(st));
    check({tag, ".b_flags"}, 32'({b_det, b_ld, b_laf, b_full, b_lfd, b_rst, b_we, b_busy, b_err, b_wto}), 32'(fl));
    check({tag, ".b_dest"}, 32'(b_dest), 32'(ds));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    a_pkt_valid = 0; a_parity_done = 0; a_fifo_full = 0; a_low = 0;
    a_data_in = 0; a_soft_reset = 0; a_fifo_empty = 3'b111;
    b_pkt_valid = 0; b_parity_done = 0; b_fifo_full = 0; b_low = 0;
    b_data_in = 0; b_soft_reset = 0; b_fifo_empty = 5'b11111;
    tick(); tick();
    resetn = 1'b1;
    chk_a("reset", 4'd0, F_DEC, 3'b000);
    chk_b("reset", 4'd0, F_DEC, 5'b00000);

    // Normal packet to channel 2
    a_pkt_valid = 1; a_data_in = 2; tick();
    chk_a("pkt2_lfd", 4'd1, F_LFD, 3'b100);
    a_data_in = 0; tick();
    chk_a("pkt2_ld", 4'd2, F_LD, 3'b100);
    tick();
    chk_a("pkt2_ld_hold", 4'd2, F_LD, 3'b100);
    a_pkt_valid = 0; tick();
    chk_a("pkt2_lp", 4'd3, F_LP, 3'b100);
    tick();
    chk_a("pkt2_chk", 4'd7, F_CHK, 3'b100);
    tick();
    chk_a("pkt2_dec", 4'd0, F_DEC, 3'b000);

    // Out-of-range header is dropped for as long as pkt_valid stays high
    a_pkt_valid = 1; a_data_in = 3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a("drop", 4'd8, F_DROP, 3'b000);
    end
    a_pkt_valid = 0; tick();
    chk_a("drop_exit", 4'd0, F_DEC, 3'b000);

    // FIFO full stall, then low_pkt_valid into parity
    a_pkt_valid = 1; a_data_in = 1; tick();
    chk_a("full_lfd", 4'd1, F_LFD, 3'b010);
    tick();
    chk_a("full_ld", 4'd2, F_LD, 3'b010);
    a_fifo_full = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("full_stall", 4'd4, F_FULL, 3'b010);
    end
    a_fifo_full = 0; tick();
    chk_a("full_laf", 4'd5, F_LAF, 3'b010);
    a_low = 1; tick();
    chk_a("laf_lp", 4'd3, F_LP, 3'b010);
    a_low = 0; a_pkt_valid = 0; tick();
    chk_a("laf_chk", 4'd7, F_CHK, 3'b010);
    a_fifo_full = 1; tick();
    chk_a("chk_full", 4'd4, F_FULL, 3'b010);
    a_fifo_full = 0; tick();
    chk_a("chk_full_laf", 4'd5, F_LAF, 3'b010);
    a_parity_done = 1; tick();
    chk_a("laf_done", 4'd0, F_DEC, 3'b000);
    a_parity_done = 0;

    // Full beats pkt_valid low in LD; parity_done beats low_pkt_valid in LAF
    a_pkt_valid = 1; a_data_in = 0; tick();
    chk_a("sim_lfd", 4'd1, F_LFD, 3'b001);
    tick();
    a_fifo_full = 1; a_pkt_valid = 0; tick();
    chk_a("sim_full_wins", 4'd4, F_FULL, 3'b001);
    a_fifo_full = 0; tick();
    a_parity_done = 1; a_low = 1; tick();
    chk_a("sim_done_wins", 4'd0, F_DEC, 3'b000);
    a_parity_done = 0; a_low = 0;

    // Soft reset of another channel is ignored; of the active channel returns to decode
    a_pkt_valid = 1; a_data_in = 1; tick(); tick();
    chk_a("sr_ld", 4'd2, F_LD, 3'b010);
    a_soft_reset = 3'b001; tick();
    chk_a("sr_other", 4'd2, F_LD, 3'b010);
    a_soft_reset = 3'b010; a_pkt_valid = 0; tick();
    chk_a("sr_hit", 4'd0, F_DEC, 3'b000);
    a_soft_reset = 3'b000;

    // Instance B: busy destination waits, then proceeds when it drains
    b_pkt_valid = 1; b_data_in = 4; b_fifo_empty = 5'b01111; tick();
    chk_b("wait_enter", 4'd6, F_WAIT, 5'b10000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b("wait_hold", 4'd6, F_WAIT, 5'b10000);
    end
    b_fifo_empty = 5'b11111; tick();
    chk_b("wait_lfd", 4'd1, F_LFD, 5'b10000);
    b_pkt_valid = 0; tick();
    chk_b("wait_ld", 4'd2, F_LD, 5'b10000);
    tick(); tick(); tick();
    chk_b("wait_dec", 4'd0, F_DEC, 5'b00000);

    // Address 5 is out of range for five channels
    b_pkt_valid = 1; b_data_in = 5; tick();
    chk_b("b_drop", 4'd8, F_DROP, 5'b00000);
    b_pkt_valid = 0; tick();
    chk_b("b_drop_exit", 4'd0, F_DEC, 5'b00000);

    // Soft reset and empty together in WAIT: decode wins
    b_pkt_valid = 1; b_data_in = 3; b_fifo_empty = 5'b10111; tick();
    chk_b("sr_wait", 4'd6, F_WAIT, 5'b01000);
    b_pkt_valid = 0; b_fifo_empty = 5'b11111; b_soft_reset = 5'b01000; tick();
    chk_b("sr_wait_exit", 4'd0, F_DEC, 5'b00000);
    b_soft_reset = 5'b00000;

    // Channel 0 never drains
    b_pkt_valid = 1; b_data_in = 0; b_fifo_empty = 5'b11110; tick();
    chk_b("to_enter", 4'd6, F_WAIT, 5'b00001);
`ifdef ROUTER_WAIT_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_b("to_wait", 4'd6, (i == 7) ? F_WTO : F_WAIT, 5'b00001);
    end
    tick();
    chk_b("to_drop", 4'd8, F_DROP, 5'b00000);
`else
    for (int i = 1; i < 20; i++) begin
      tick();
      chk_b("no_to_wait", 4'd6, F_WAIT, 5'b00001);
    end
`endif

    // Reset mid-packet
    resetn = 1'b0; tick();
    resetn = 1'b1; b_pkt_valid = 0;
    chk_b("reset_mid", 4'd0, F_DEC, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
# router_fsm_nch

Parametrised controller FSM for the 1xN router. Sits between the register block, the synchroniser and the N output FIFOs. It decodes the header address, sequences header, payload and parity loading, and stalls on FIFO full. Compared with the fixed 3-channel controller it adds a configurable channel count and address width, a discard path for out-of-range addresses, and an optional timeout for a destination FIFO that never drains.

## Interface
- NUM_CH, 3, number of output channels; legal range 2..2**ADDR_W
- ADDR_W, 2, width of the header address field
- WAIT_CYCLES, 255, WAIT_TILL_EMPTY timeout limit; used only with ROUTER_WAIT_TIMEOUT_EN
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- pkt_valid  in  1  packet byte valid from source
- parity_done  in  1  parity byte written (register block)
- data_in  in  ADDR_W  header address bits (data_in[ADDR_W-1:0] of the byte bus)
- soft_reset  in  NUM_CH  per-channel read-timeout soft reset (synchroniser)
- fifo_full  in  1  full flag of the selected FIFO (synchroniser)
- low_pkt_valid  in  1  pkt_valid fell while in full/after-full (register block)
- fifo_empty  in  NUM_CH  per-channel empty flags
- detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg, write_enb_reg, busy  out  1 each  state decodes
- dest_sel  out  NUM_CH  one-hot latched destination
- addr_err  out  1  high in DROP_PACKET
- wait_timeout  out  1  one-cycle pulse on timeout exit from WAIT_TILL_EMPTY

## Operation
- States, 4-bit encoding: DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, LOAD_DATA=2, LOAD_PARITY=3, FIFO_FULL_STATE=4, LOAD_AFTER_FULL=5, WAIT_TILL_EMPTY=6, CHECK_PARITY_ERROR=7, DROP_PACKET=8. Undefined codes go to DECODE_ADDRESS.
- addr_q (ADDR_W bits, reset 0) loads data_in on every cycle with detect_add=1.
- DECODE_ADDRESS:
  - pkt_valid=0: stay.
  - pkt_valid=1 and data_in>=NUM_CH: go to DROP_PACKET.
  - pkt_valid=1 and fifo_empty[data_in]=1: go to LOAD_FIRST_DATA.
  - pkt_valid=1 otherwise: go to WAIT_TILL_EMPTY.
- LOAD_FIRST_DATA: go to LOAD_DATA.
- LOAD_DATA:
  - fifo_full=1: go to FIFO_FULL_STATE.
  - else pkt_valid=0: go to LOAD_PARITY.
  - else stay.
- LOAD_PARITY: go to CHECK_PARITY_ERROR.
- FIFO_FULL_STATE: stay while fifo_full=1, else go to LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - parity_done=1: go to DECODE_ADDRESS.
  - else low_pkt_valid=1: go to LOAD_PARITY.
  - else go to LOAD_DATA.
- WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 goes to LOAD_FIRST_DATA, else stay (timeout exit under Configuration).
- CHECK_PARITY_ERROR: fifo_full=0 goes to DECODE_ADDRESS, else FIFO_FULL_STATE.
- DROP_PACKET: stay while pkt_valid=1, go to DECODE_ADDRESS when pkt_valid=0. Packet bytes are discarded.
- Soft reset: if addr_q<NUM_CH and soft_reset[addr_q]=1, the next state is DECODE_ADDRESS from any state. It overrides next-state logic but not resetn. Ignored when addr_q>=NUM_CH.
- Output decodes:
  - Single-state decodes are Moore: detect_add=DECODE, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FULL, rst_int_reg=CHECK, addr_err=DROP.
  - write_enb_reg = LD | LAF | LOAD_PARITY.
  - busy = LFD | LOAD_PARITY | FULL | LAF | WAIT | CHECK. busy is 0 in DECODE, LD and DROP.
  - dest_sel = one-hot(addr_q) in every state except DECODE and DROP, where it is all zeros.

## Timing
- Reset values: state DECODE_ADDRESS, addr_q=0, timeout counter 0.
- Outputs after reset: detect_add=1, every other output 0, dest_sel=0.
- Reset is applied at the next clock edge and overrides everything, including mid-packet.
- State outputs are pure decodes of the state register, so they change one cycle after the qualifying input edge.
- A header accepted at edge k gives lfd_state=1 in cycle k+1 and ld_state=1 in cycle k+2.
- Header byte, address decode and addr_q load happen in the same cycle.
- Simultaneous events:
  - fifo_full=1 and pkt_valid=0 in LOAD_DATA: FIFO_FULL_STATE wins.
  - parity_done=1 and low_pkt_valid=1 in LAF: DECODE_ADDRESS wins.
  - soft_reset and fifo_empty both high in WAIT: DECODE_ADDRESS.

## Configuration
- Macro ROUTER_WAIT_TIMEOUT_EN, defined:
  - A counter of width $clog2(WAIT_CYCLES+1) clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - If fifo_empty[addr_q]=0 and the counter equals WAIT_CYCLES-1, the next state is DROP_PACKET and wait_timeout pulses for that one cycle.
  - An empty FIFO in that same cycle takes priority (go to LOAD_FIRST_DATA, no pulse).
- Macro not defined: WAIT_TILL_EMPTY waits indefinitely, no counter is built, wait_timeout is tied 0.

## Test plan
- NUM_CH=3: reset, then pkt_valid=1, data_in=2, fifo_empty=3'b111 -> lfd_state next cycle, dest_sel=3'b100, ld_state after it; drop pkt_valid -> LOAD_PARITY, CHECK (rst_int_reg=1), DECODE.
- NUM_CH=3: header data_in=3 with pkt_valid held high 5 cycles -> addr_err=1, busy=0, write_enb_reg=0 for those cycles; pkt_valid low -> detect_add=1.
- fifo_full=1 during LOAD_DATA for 4 cycles -> full_state=1 for 4 cycles, then laf_state=1; with low_pkt_valid=1 -> LOAD_PARITY.
- NUM_CH=5, ADDR_W=3: header data_in=4, fifo_empty[4]=0 -> WAIT, busy=1; fifo_empty[4]=1 -> LOAD_FIRST_DATA next cycle.
- In LD with addr_q=1, pulse soft_reset[1] -> DECODE next cycle. Pulse soft_reset[0] instead -> no effect.
- ROUTER_WAIT_TIMEOUT_EN, WAIT_CYCLES=8, fifo_empty[0] stuck 0 -> exactly 8 cycles in WAIT, wait_timeout pulses once, then DROP_PACKET.
